// File: rtl/instr_pkg.sv
// Shared types and field positions for the instruction decode pipeline.
package instr_pkg;

    // Control-field bit positions inside a C-instruction.
    localparam int CTRL_W   = 13;
    localparam int A_BIT    = 12;
    localparam int C_MSB    = 11;
    localparam int C_LSB    = 6;
    localparam int D_MSB    = 5;
    localparam int D_LSB    = 3;
    localparam int J_MSB    = 2;
    localparam int J_LSB    = 0;

    // Bits that must both be set for a C-instruction to be legal.
    localparam int ID_HI_BIT = 14;
    localparam int ID_LO_BIT = 13;

    // Control fields in the order {a, c1..c6, d1..d3, j1..j3}.
    typedef struct packed {
        logic       a;
        logic [5:0] c;
        logic [2:0] d;
        logic [2:0] j;
    } ctrl_t;

    // Decoded part of a buffered entry; the instruction value travels beside it.
    typedef struct packed {
        logic  itype;
        logic  illegal;
        ctrl_t ctrl;
    } entry_t;

    localparam int ENTRY_META_W = $bits(entry_t);

    // Occupancy of the two-entry buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } occ_state_t;

    // Map the low 13 instruction bits onto the control struct.
    function automatic ctrl_t pick_ctrl(input logic [CTRL_W-1:0] bits13);
        ctrl_t f;
        f.a = bits13[A_BIT];
        f.c = bits13[C_MSB:C_LSB];
        f.d = bits13[D_MSB:D_LSB];
        f.j = bits13[J_MSB:J_LSB];
        return f;
    endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry in-order buffer with registered ready/valid and an occupancy FSM.
module decode_skid_buf
    import instr_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_state_t   state_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic         push_s;
    logic         pop_s;

    // Transfers use the registered handshake flags only.
    always_comb begin
        push_s = in_valid & in_ready_r;
        pop_s  = out_valid_r & out_ready;
    end

    // Occupancy FSM with storage and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_r      <= {W{1'b0}};
            tail_r      <= {W{1'b0}};
        end else if (flush) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        head_r      <= in_data;
                        state_r     <= ST_ONE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        head_r <= in_data;
                    end else if (push_s) begin
                        tail_r      <= in_data;
                        state_r     <= ST_TWO;
                        in_ready_r  <= 1'b0;
                    end else if (pop_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        head_r     <= tail_r;
                        state_r    <= ST_ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = head_r;

endmodule

// File: rtl/instr_decode_pipe.sv
// Instruction decoder: decodes at acceptance, buffers two entries, counts types.
module instr_decode_pipe
    import instr_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_instr,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_type,
    output logic [DW-1:0] out_value,
    output logic [12:0]   out_ctrl,
    output logic          out_illegal,
    output logic [CW-1:0] cnt_a,
    output logic [CW-1:0] cnt_c
);

    localparam int EW = DW + ENTRY_META_W;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    entry_t        meta_s;
    logic [DW-1:0] value_s;
    logic [EW-1:0] buf_in_s;
    logic [EW-1:0] buf_out_s;
    entry_t        head_meta_s;
    logic          accept_s;
    logic [CW-1:0] cnt_a_r;
    logic [CW-1:0] cnt_c_r;

    // Decode the incoming instruction; illegal C-instructions carry no controls.
    always_comb begin
        meta_s.itype   = in_instr[DW-1];
        meta_s.illegal = 1'b0;
        meta_s.ctrl    = pick_ctrl(13'd0);
        if (in_instr[DW-1]) begin
            if (in_instr[ID_HI_BIT:ID_LO_BIT] != 2'b11) begin
                meta_s.illegal = 1'b1;
                meta_s.ctrl    = pick_ctrl(13'd0);
            end else begin
                meta_s.illegal = 1'b0;
                meta_s.ctrl    = pick_ctrl(in_instr[CTRL_W-1:0]);
            end
        end else begin
            meta_s.illegal = 1'b0;
            meta_s.ctrl    = pick_ctrl(13'd0);
        end
    end

    assign value_s  = {1'b0, in_instr[DW-2:0]};
    assign buf_in_s = {meta_s, value_s};

    // A flushed push never enters the buffer, so it is not counted either.
    assign accept_s = in_valid & in_ready & ~flush;

    decode_skid_buf #(
        .W (EW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (buf_in_s),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out_s)
    );

    assign head_meta_s = entry_t'(buf_out_s[EW-1:DW]);
    assign out_type    = head_meta_s.itype;
    assign out_illegal = head_meta_s.illegal;
    assign out_ctrl    = head_meta_s.ctrl;
    assign out_value   = buf_out_s[DW-1:0];

    // Saturating per-type acceptance counters; flush leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a_r <= {CW{1'b0}};
            cnt_c_r <= {CW{1'b0}};
        end else if (accept_s) begin
            if (meta_s.itype) begin
                if (cnt_c_r != CNT_MAX) begin
                    cnt_c_r <= cnt_c_r + CNT_ONE;
                end
            end else begin
                if (cnt_a_r != CNT_MAX) begin
                    cnt_a_r <= cnt_a_r + CNT_ONE;
                end
            end
        end
    end

    assign cnt_a = cnt_a_r;
    assign cnt_c = cnt_c_r;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed self-checking bench for instr_decode_pipe.
module tb_instr_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        out_type;
    logic [15:0] out_value;
    logic [12:0] out_ctrl;
    logic        out_illegal;
    logic [3:0]  cnt_a;
    logic [3:0]  cnt_c;

    // Wide instance shares the control inputs
    logic [23:0] w_instr;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_out_type;
    logic [23:0] w_out_value;
    logic [12:0] w_out_ctrl;
    logic        w_out_illegal;
    logic [15:0] w_cnt_a;
    logic [15:0] w_cnt_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_decode_pipe #(.DW(16), .CW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_value(out_value), .out_ctrl(out_ctrl),
        .out_illegal(out_illegal), .cnt_a(cnt_a), .cnt_c(cnt_c)
    );

    instr_decode_pipe #(.DW(24), .CW(16)) dut_w (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_instr(w_instr), .in_ready(w_in_ready),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_type(w_out_type), .out_value(w_out_value), .out_ctrl(w_out_ctrl),
        .out_illegal(w_out_illegal), .cnt_a(w_cnt_a), .cnt_c(w_cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 16'h0000;
        w_instr = 24'h000000; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_cnt_c", 32'(cnt_c), 32'd0);
        chk("rst_value", 32'(out_value), 32'd0);
        chk("rst_type", 32'(out_type), 32'd0);
        chk("rst_ctrl", 32'(out_ctrl), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        chk("w_rst_in_ready", 32'(w_in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // A-instruction
        in_valid = 1'b1; in_instr = 16'h0015; w_instr = 24'h408015; out_ready = 1'b1;
        tick();
        chk("a_valid", 32'(out_valid), 32'd1);
        chk("a_type", 32'(out_type), 32'd0);
        chk("a_value", 32'(out_value), 32'h0015);
        chk("a_ctrl", 32'(out_ctrl), 32'd0);
        chk("a_illegal", 32'(out_illegal), 32'd0);
        chk("a_cnt_a", 32'(cnt_a), 32'd1);
        chk("w_a_type", 32'(w_out_type), 32'd0);
        chk("w_a_value", 32'(w_out_value), 32'h408015);
        chk("w_a_ctrl", 32'(w_out_ctrl), 32'd0);
        chk("w_a_cnt_a", 32'(w_cnt_a), 32'd1);

        // Legal C-instruction
        in_instr = 16'hEC10; w_instr = 24'hD5EC10;
        tick();
        chk("c_valid", 32'(out_valid), 32'd1);
        chk("c_type", 32'(out_type), 32'd1);
        chk("c_value", 32'(out_value), 32'h6C10);
        chk("c_ctrl", 32'(out_ctrl), 32'(13'b0_110000_010_000));
        chk("c_illegal", 32'(out_illegal), 32'd0);
        chk("c_cnt_c", 32'(cnt_c), 32'd1);
        chk("w_c_type", 32'(w_out_type), 32'd1);
        chk("w_c_value", 32'(w_out_value), 32'h55EC10);
        chk("w_c_ctrl", 32'(w_out_ctrl), 32'h0C10);
        chk("w_c_illegal", 32'(w_out_illegal), 32'd0);
        chk("w_c_cnt_c", 32'(w_cnt_c), 32'd1);

        // Illegal C-instruction
        in_instr = 16'h8C10;
        tick();
        chk("ill_type", 32'(out_type), 32'd1);
        chk("ill_value", 32'(out_value), 32'h0C10);
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_ctrl", 32'(out_ctrl), 32'd0);
        chk("ill_cnt_c", 32'(cnt_c), 32'd2);

        // Drain
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_ready", 32'(in_ready), 32'd1);

        // Backpressure: two fit, third waits
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h0001;
        tick();
        chk("bp1_ready", 32'(in_ready), 32'd1);
        in_instr = 16'h0002;
        tick();
        chk("bp2_ready", 32'(in_ready), 32'd0);
        chk("bp2_value", 32'(out_value), 32'h0001);
        in_instr = 16'h0003;
        tick();
        chk("bp3_ready", 32'(in_ready), 32'd0);
        chk("bp3_hold", 32'(out_value), 32'h0001);
        chk("bp3_valid", 32'(out_valid), 32'd1);
        chk("bp3_cnt_a", 32'(cnt_a), 32'd3);
        out_ready = 1'b1;
        tick();
        chk("rel1_value", 32'(out_value), 32'h0002);
        chk("rel1_ready", 32'(in_ready), 32'd1);
        tick();
        chk("rel2_value", 32'(out_value), 32'h0003);
        chk("rel2_cnt_a", 32'(cnt_a), 32'd4);
        in_valid = 1'b0;
        tick();
        chk("rel3_valid", 32'(out_valid), 32'd0);

        // Saturation of a 4-bit counter
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_instr = 16'h0100 + 16'(i);
            tick();
            if (i == 9) chk("sat_14", 32'(cnt_a), 32'd14);
            if (i == 10) chk("sat_15", 32'(cnt_a), 32'd15);
        end
        chk("sat_hold", 32'(cnt_a), 32'd15);
        chk("sat_value", 32'(out_value), 32'h0110);

        // Flush with simultaneous push
        flush = 1'b1; in_instr = 16'hEC10; out_ready = 1'b0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_cnt_a", 32'(cnt_a), 32'd15);
        chk("flush_cnt_c", 32'(cnt_c), 32'd2);

        // Async reset while full
        in_valid = 1'b1; in_instr = 16'h0005;
        tick();
        in_instr = 16'h0006;
        tick();
        in_valid = 1'b0;
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_cnt_a", 32'(cnt_a), 32'd0);
        chk("arst_cnt_c", 32'(cnt_c), 32'd0);
        chk("arst_value", 32'(out_value), 32'd0);
        #2 rst = 1'b0;

        // Recovery with an all-ones C-instruction
        in_valid = 1'b1; in_instr = 16'hFFFF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rec_valid", 32'(out_valid), 32'd1);
        chk("rec_value", 32'(out_value), 32'h7FFF);
        chk("rec_ctrl", 32'(out_ctrl), 32'h1FFF);
        chk("rec_illegal", 32'(out_illegal), 32'd0);
        chk("rec_cnt_c", 32'(cnt_c), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
